// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shifter with a valid/ready load port.
// Words are sent MSB-first, one bit per clk, and can stream back-to-back.
// Optional feature: define PISO_SERIALIZER_PARITY_EN to append one even-parity
// beat after bit 0 of every word.
// Reset is synchronous and active-low on rst.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NBEATS = WIDTH + 1;
`else
  localparam int NBEATS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  // Beats still to come after the one presented right after a load.
  localparam logic [CW-1:0] LOAD_CNT = CW'(NBEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n, valid_n, last_n, busy_n;
  logic             handshake;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_q, parity_n;
`endif

  // A new word may enter when idle or while the previous word shows its last beat.
  assign load_ready = rst & ((state == IDLE) | sout_last);
  assign handshake  = load_valid & load_ready;

  // Next-state and next-output logic: load, advance one beat, or drop back to idle.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    cnt_n     = cnt;
    sout_n    = sout;
    valid_n   = sout_valid;
    last_n    = sout_last;
    busy_n    = busy;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_n  = parity_q;
`endif
    if (handshake) begin
      state_n  = SHIFT;
      sout_n   = din[WIDTH-1];
      shift_n  = {din[WIDTH-2:0], 1'b0};
      cnt_n    = LOAD_CNT;
      valid_n  = 1'b1;
      last_n   = 1'b0;
      busy_n   = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_n = ^din;
`endif
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        state_n = IDLE;
        shift_n = '0;
        sout_n  = 1'b0;
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
      end else begin
        cnt_n   = cnt - CW'(1);
        last_n  = (cnt == CW'(1));
        shift_n = {shift_reg[WIDTH-2:0], 1'b0};
`ifdef PISO_SERIALIZER_PARITY_EN
        sout_n  = (cnt == CW'(1)) ? parity_q : shift_reg[WIDTH-1];
`else
        sout_n  = shift_reg[WIDTH-1];
`endif
      end
    end
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shift_reg  <= shift_n;
      cnt        <= cnt_n;
      sout       <= sout_n;
      sout_valid <= valid_n;
      sout_last  <= last_n;
      busy       <= busy_n;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q   <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and random stimulus for piso_serializer, checked
// against a queue-of-beats reference model. Honours PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  // Beats not yet retired; the front is what the DUT should be showing now.
  beat_t q[$];

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expand an accepted word into its beats: data MSB-first, then parity if enabled.
  task automatic push_word(input logic [WIDTH-1:0] d);
    beat_t t;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      t.b    = d[i];
      t.last = (i == 0) && !PAR;
      q.push_back(t);
    end
    if (PAR) begin
      t.b    = logic'($countones(d) % 2);
      t.last = 1'b1;
      q.push_back(t);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare registered outputs with the model front.
  task automatic check_output();
    logic ev, eb, el;
    ev = (q.size() > 0);
    eb = ev ? q[0].b : 1'b0;
    el = ev ? q[0].last : 1'b0;
    check_bit("sout_valid", sout_valid, ev);
    check_bit("busy", busy, ev);
    check_bit("sout_last", sout_last, el);
    check_bit("sout", sout, eb);
  endtask

  // Drive one cycle: check load_ready, clock, update model, check outputs.
  task automatic apply_stimulus(input logic r, input logic v, input logic [WIDTH-1:0] d);
    logic rdy_exp;
    rst = r;
    load_valid = v;
    din = d;
    #1;
    rdy_exp = r && (q.size() <= 1);
    check_bit("load_ready", load_ready, rdy_exp);
    @(posedge clk);
    if (!r) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v && rdy_exp) push_word(d);
    end
    #1;
    check_output();
  endtask

  // Idle cycles with no load offered.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, '0);
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] captured;
    rst = 1'b0;
    load_valid = 1'b0;
    din = '0;

    // Reset state.
    apply_stimulus(1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 8'hA5);

    // Idle stability after reset.
    idle_cycles(20);

    // Single word 8'hA5, with an explicit reassembly of the serial bits.
    apply_stimulus(1'b1, 1'b1, 8'hA5);
    captured = '0;
    captured = {captured[WIDTH-2:0], sout};
    for (int i = 1; i < WIDTH; i++) begin
      apply_stimulus(1'b1, 1'b0, '0);
      captured = {captured[WIDTH-2:0], sout};
    end
    check_bit("a5_last_on_bit0", sout_last, !PAR);
    checks++;
    assert (captured === 8'hA5) else begin
      errors++;
      $error("[TB] FAIL a5_serial: observed %h expected %h", captured, 8'hA5);
    end
    idle_cycles(3);

    // Back-to-back 8'hFF then 8'h00 loaded during the last beat.
    apply_stimulus(1'b1, 1'b1, 8'hFF);
    for (int i = 1; i < WIDTH + int'(PAR); i++) apply_stimulus(1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 8'h00);
    idle_cycles(WIDTH + 3);

    // Parity words (plain data when parity is disabled).
    apply_stimulus(1'b1, 1'b1, 8'h07);
    idle_cycles(WIDTH + 2);
    apply_stimulus(1'b1, 1'b1, 8'h03);
    idle_cycles(WIDTH + 2);

    // Backpressure: din changes while the word is in flight.
    apply_stimulus(1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < WIDTH + int'(PAR); i++) apply_stimulus(1'b1, 1'b1, 8'hC3);
    idle_cycles(WIDTH + 3);

    // Mid-word reset during beat 4, then a clean word.
    apply_stimulus(1'b1, 1'b1, 8'hA5);
    idle_cycles(3);
    apply_stimulus(1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 8'hFF);
    apply_stimulus(1'b1, 1'b1, 8'h81);
    idle_cycles(WIDTH + 3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rd = WIDTH'($urandom);
      apply_stimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), rd);
    end
    idle_cycles(WIDTH + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
